// File: rtl/fc_dma_reader.sv
// Burst reader for the FC stage: issues sequential single-word reads and streams
// each returned word with its burst index, then pulses DMA_ready once.
module fc_dma_reader #(
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int LAYER_SZ          = 7,
  parameter int DATA_WIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         DMA_read,
  input  logic [MEM_ADDRESS_WIDTH-1:0] DMA_address,
  input  logic [LAYER_SZ-1:0]          DMA_count,
  output logic                         DMA_ready,
  output logic                         busy,
  output logic                         mem_rd,
  output logic [MEM_ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [LAYER_SZ-1:0]          out_index
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                         state;
  logic [MEM_ADDRESS_WIDTH-1:0]   base;
  logic [LAYER_SZ-1:0]            count;
  logic [LAYER_SZ-1:0]            issued;
  logic [LAYER_SZ-1:0]            rd_index;

  // The memory registers its read data on the edge after mem_rd, so the word
  // is on mem_rdata during the out_valid cycle; mask it so idle/reset shows 0.
  assign out_data = out_valid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= '0;
      count     <= '0;
      issued    <= '0;
      rd_index  <= '0;
      DMA_ready <= 1'b0;
      busy      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
    end else if (clk_en) begin
      out_valid <= mem_rd;
      if (mem_rd) begin
        out_index <= rd_index;
      end

      case (state)
        IDLE, DONE: begin
          DMA_ready <= 1'b0;
          if (DMA_read) begin
            base   <= DMA_address;
            count  <= DMA_count;
            issued <= '0;
            busy   <= 1'b1;
            // An empty burst skips straight to the completion wait.
            state  <= (DMA_count == '0) ? DRAIN : READ;
          end else begin
            state <= IDLE;
          end
        end

        READ: begin
          mem_rd   <= 1'b1;
          mem_addr <= base + MEM_ADDRESS_WIDTH'(issued);
          rd_index <= issued;
          issued   <= issued + LAYER_SZ'(1);
          if (issued == count - LAYER_SZ'(1)) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          mem_rd <= 1'b0;
          // Complete once no read is outstanding: the last word is on the bus now.
          if (!mem_rd) begin
            state     <= DONE;
            busy      <= 1'b0;
            DMA_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_dma_reader.sv
// Scoreboard bench for fc_dma_reader: directed bursts push expected reads, words
// and completion cycles; a negedge monitor pops and compares as outputs appear.
module tb_fc_dma_reader;
  localparam int AW = 10;
  localparam int LW = 7;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_en = 1'b1;
  logic          DMA_read = 1'b0;
  logic [AW-1:0] DMA_address = '0;
  logic [LW-1:0] DMA_count = '0;
  logic          DMA_ready;
  logic          busy;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_index;

  fc_dma_reader #(.MEM_ADDRESS_WIDTH(AW), .LAYER_SZ(LW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .DMA_read(DMA_read),
    .DMA_address(DMA_address), .DMA_count(DMA_count), .DMA_ready(DMA_ready),
    .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index)
  );

  always #5 clk = ~clk;

  // Memory contents: mem[k] = k, except mem[1] = 0x00AB.
  function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
    return (a == AW'(1)) ? 16'h00AB : DW'(a);
  endfunction

  always @(posedge clk) if (clk_en && mem_rd) mem_rdata <= mem_word(mem_addr);

  int ecyc = 0;
  bit last_en = 1'b0;
  always @(posedge clk) begin
    last_en = clk_en;
    if (clk_en) ecyc = ecyc + 1;
  end

  typedef struct { int cyc; logic [DW-1:0] data; logic [LW-1:0] idx; } word_t;
  typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
  word_t wq[$];
  rd_t   aq[$];
  int    rq[$];

  int checks = 0;
  int failures = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at ecyc=%0d", name, got, exp, ecyc);
    end
  endfunction

  function automatic logic [63:0] outs();
    return 64'({DMA_ready, busy, mem_rd, mem_addr, out_valid, out_data, out_index});
  endfunction

  // Monitor
  word_t       w;
  rd_t         r;
  int          rc;
  logic [63:0] snap = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (!last_en) begin
        check("frozen_outputs", outs(), snap);
      end else begin
        if (out_valid) begin
          if (wq.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'd0);
          else begin
            w = wq.pop_front();
            check("out_cycle", 64'(ecyc), 64'(w.cyc));
            check("out_data", 64'(out_data), 64'(w.data));
            check("out_index", 64'(out_index), 64'(w.idx));
          end
        end
        if (mem_rd) begin
          if (aq.size() == 0) check("unexpected_mem_rd", 64'(mem_rd), 64'd0);
          else begin
            r = aq.pop_front();
            check("rd_cycle", 64'(ecyc), 64'(r.cyc));
            check("mem_addr", 64'(mem_addr), 64'(r.addr));
          end
        end
        if (DMA_ready) begin
          if (rq.size() == 0) check("unexpected_ready", 64'(DMA_ready), 64'd0);
          else begin
            rc = rq.pop_front();
            check("ready_cycle", 64'(ecyc), 64'(rc));
            check("busy_at_ready", 64'(busy), 64'd0);
          end
        end
      end
      snap = outs();
    end
  end

  task automatic push_exp(int addr, int cnt, int t);
    for (int i = 0; i < cnt; i++) begin
      aq.push_back('{t + 1 + i, AW'(addr + i)});
      wq.push_back('{t + 2 + i, mem_word(AW'(addr + i)), LW'(i)});
    end
    rq.push_back(cnt == 0 ? t + 1 : t + cnt + 2);
  endtask

  task automatic start(int addr, int cnt);
    int t;
    DMA_read    = 1'b1;
    DMA_address = AW'(addr);
    DMA_count   = LW'(cnt);
    t = ecyc + 1;
    push_exp(addr, cnt, t);
    @(negedge clk); #1;
    DMA_read = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((wq.size() + aq.size() + rq.size()) != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(wq.size() + aq.size() + rq.size()), 64'd0);
  endtask

  initial begin
    int t1, t2;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", outs(), 64'd0);
    rst = 1'b1;
    @(negedge clk); #1;

    // Single-word burst
    start(1, 1);
    wait_drain(20);
    check("busy_idle", 64'(busy), 64'd0);

    // 120-word burst followed back-to-back by an 84-word burst
    DMA_read = 1'b1; DMA_address = AW'(2); DMA_count = LW'(120);
    t1 = ecyc + 1;
    push_exp(2, 120, t1);
    @(negedge clk); #1;
    DMA_address = AW'(300); DMA_count = LW'(84);
    t2 = t1 + 120 + 3;
    push_exp(300, 84, t2);
    while (ecyc < t2) begin @(negedge clk); #1; end
    DMA_read = 1'b0;
    wait_drain(300);

    // Address wrap
    start(1022, 4);
    wait_drain(20);

    // Zero-count burst
    start(5, 0);
    wait_drain(10);
    repeat (3) begin @(negedge clk); #1; end

    // Request while busy is ignored
    start(500, 5);
    @(negedge clk); #1;
    DMA_read = 1'b1; DMA_address = AW'(700); DMA_count = LW'(9);
    @(negedge clk); #1;
    DMA_read = 1'b0;
    wait_drain(20);

    // Clock-enable stall mid-burst
    start(10, 8);
    repeat (2) begin @(negedge clk); #1; end
    clk_en = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    clk_en = 1'b1;
    wait_drain(30);

    // Reset mid-burst, then a normal burst
    start(40, 10);
    repeat (3) begin @(negedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    wq.delete(); aq.delete(); rq.delete();
    check("midburst_reset_outputs", outs(), 64'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (10) begin @(negedge clk); #1; end
    start(60, 3);
    wait_drain(20);
    check("final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
